// File: rtl/i_ram_loader.sv
// Boot-time instruction RAM loader: takes a byte stream over valid/ready, builds
// big-endian 32-bit words and writes them at BASE_ADDRESS onward, then gives the
// RAM address port to the CPU fetch path.
// Latency: one header cycle plus 5 cycles per word (4 byte accepts + 1 write).
// Backpressure: byte_ready is high only in COUNT/COLLECT; a WRITE cycle stalls the link for one cycle.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   start_load            single-cycle (re)load request, honoured in IDLE/RUN/ERROR
//   byte_in/valid/ready   loader byte stream handshake
//   pc_address            CPU fetch address, passed through to ram_address in RUN
//   ram_address           instruction RAM address
//   i_ram_input           RAM write data (always the assembly shift register)
//   flag_write_i_ram      RAM write enable, one cycle per word
//   cpu_hold              CPU stall, low only in RUN
//   load_done             program loaded, CPU running
//   load_error            length header exceeded MAX_WORDS
module i_ram_loader #(
    parameter int ADDR_WIDTH   = 10,
    parameter int BASE_ADDRESS = 20,
    parameter int MAX_WORDS    = 31
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_load,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic [ADDR_WIDTH-1:0] pc_address,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [31:0]           i_ram_input,
    output logic                  flag_write_i_ram,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_COLLECT,
        S_WRITE,
        S_RUN,
        S_ERROR
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDRESS);
    localparam logic [31:0]           MAX_W = 32'(MAX_WORDS);

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   index;
    logic [ADDR_WIDTH-1:0]   index_next;
    logic [7:0]              n_words;
    logic [1:0]              byte_cnt;
    logic [31:0]             shift_reg;

    logic byte_accept;
    logic header_zero;
    logic header_too_big;
    logic last_word;

    assign byte_accept    = byte_valid && byte_ready;
    assign header_zero    = (byte_in == 8'd0);
    assign header_too_big = ({24'd0, byte_in} > MAX_W);
    assign index_next     = index + 1'b1;
    // Compare at 32 bits so neither operand is truncated whatever ADDR_WIDTH is.
    assign last_word      = (32'(index_next) == 32'(n_words));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_load) state_next = S_COUNT;
            end
            S_COUNT: begin
                if (byte_accept) begin
                    if (header_zero)         state_next = S_RUN;
                    else if (header_too_big) state_next = S_ERROR;
                    else                     state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (byte_accept && (byte_cnt == 2'd3)) state_next = S_WRITE;
            end
            S_WRITE: begin
                state_next = last_word ? S_RUN : S_COLLECT;
            end
            S_RUN: begin
                if (start_load) state_next = S_COUNT;
            end
            S_ERROR: begin
                if (start_load) state_next = S_COUNT;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        byte_ready       = 1'b0;
        flag_write_i_ram = 1'b0;
        cpu_hold         = 1'b1;
        load_done        = 1'b0;
        load_error       = 1'b0;
        ram_address      = BASE;
        i_ram_input      = shift_reg;
        case (state)
            S_COUNT, S_COLLECT: begin
                byte_ready = 1'b1;
            end
            S_WRITE: begin
                flag_write_i_ram = 1'b1;
                ram_address      = BASE + index;  // wraps modulo 2^ADDR_WIDTH
            end
            S_RUN: begin
                cpu_hold    = 1'b0;
                load_done   = 1'b1;
                ram_address = pc_address;         // straight through, no added latency
            end
            S_ERROR: begin
                load_error = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: word count, word index, byte counter and assembly shift register
    always_ff @(posedge clock) begin
        if (reset) begin
            index     <= '0;
            n_words   <= 8'd0;
            byte_cnt  <= 2'd0;
            shift_reg <= 32'd0;
        end else begin
            case (state)
                S_COUNT: begin
                    if (byte_accept && !header_zero && !header_too_big) begin
                        n_words  <= byte_in;
                        index    <= '0;
                        byte_cnt <= 2'd0;
                    end
                end
                S_COLLECT: begin
                    if (byte_accept) begin
                        // MSB-first: the first byte of a word ends up in [31:24].
                        shift_reg <= {shift_reg[23:0], byte_in};
                        byte_cnt  <= byte_cnt + 2'd1;   // wraps to 0 on the 4th byte
                    end
                end
                S_WRITE: begin
                    index <= index_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i_ram_loader.sv
module tb_i_ram_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_load;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [9:0]  pc_address;
    logic [9:0]  ram_address;
    logic [31:0] i_ram_input;
    logic        flag_write_i_ram;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ready_in_write = 0;

    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    i_ram_loader #(
        .ADDR_WIDTH  (10),
        .BASE_ADDRESS(20),
        .MAX_WORDS   (31)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start_load      (start_load),
        .byte_in         (byte_in),
        .byte_valid      (byte_valid),
        .byte_ready      (byte_ready),
        .pc_address      (pc_address),
        .ram_address     (ram_address),
        .i_ram_input     (i_ram_input),
        .flag_write_i_ram(flag_write_i_ram),
        .cpu_hold        (cpu_hold),
        .load_done       (load_done),
        .load_error      (load_error)
    );

    always #5 clock = ~clock;

    // Log every RAM write pulse and any cycle where byte_ready overlaps a write.
    always @(posedge clock) begin
        if (flag_write_i_ram) begin
            wr_addr.push_back(ram_address);
            wr_data.push_back(i_ram_input);
            if (byte_ready) ready_in_write++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte and hold it until accepted; optional idle cycle first.
    task automatic send(input logic [7:0] b, input bit gap);
        bit done;
        if (gap) begin
            byte_valid = 1'b0;
            tick();
        end
        byte_in    = b;
        byte_valid = 1'b1;
        done       = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (byte_ready) done = 1'b1;
            tick();
        end
        byte_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte=%0h not accepted within 20 cycles", b);
        end
    endtask

    task automatic pulse_start();
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        cyc = 0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic load_two_words(input bit gap);
        send(8'h02, gap);
        send(8'h80, gap); send(8'h40, gap); send(8'h00, gap); send(8'h00, gap);
        send(8'h80, gap); send(8'h60, gap); send(8'h00, gap); send(8'h00, gap);
    endtask

    initial begin
        reset      = 1'b1;
        start_load = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        pc_address = 10'd0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // Reset / idle state
        chk("rst_cpu_hold",   32'(cpu_hold),         32'd1);
        chk("rst_byte_ready", 32'(byte_ready),       32'd0);
        chk("rst_write",      32'(flag_write_i_ram), 32'd0);
        chk("rst_load_done",  32'(load_done),        32'd0);
        chk("rst_load_error", 32'(load_error),       32'd0);
        chk("rst_ram_addr",   32'(ram_address),      32'd20);
        chk("rst_ram_data",   i_ram_input,           32'd0);

        // Back-to-back two-word load
        clear_log();
        pulse_start();
        chk("count_ready", 32'(byte_ready), 32'd1);
        send(8'h02, 1'b0);
        chk("collect_addr", 32'(ram_address), 32'd20);
        send(8'h80, 1'b0); send(8'h40, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        send(8'h80, 1'b0); send(8'h60, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        chk("b2b_cyc_last_accept", 32'(cyc), 32'd10);
        chk("b2b_w1_write",   32'(flag_write_i_ram), 32'd1);
        chk("b2b_w1_addr",    32'(ram_address),      32'd21);
        chk("b2b_w1_data",    i_ram_input,           32'h80600000);
        chk("b2b_w1_ready",   32'(byte_ready),       32'd0);
        chk("b2b_w1_done",    32'(load_done),        32'd0);
        pc_address = 10'd22;
        tick();
        chk("b2b_run_cyc",    32'(cyc),              32'd11);
        chk("b2b_load_done",  32'(load_done),        32'd1);
        chk("b2b_cpu_hold",   32'(cpu_hold),         32'd0);
        chk("b2b_pc_addr",    32'(ram_address),      32'd22);
        pc_address = 10'd300;
        #1;
        chk("b2b_pc_track",   32'(ram_address),      32'd300);
        chk("b2b_nwrites",    32'(wr_addr.size()),   32'd2);
        chk("b2b_w0_addr",    32'(wr_addr[0]),       32'd20);
        chk("b2b_w0_data",    wr_data[0],            32'h80400000);
        chk("b2b_w1_laddr",   32'(wr_addr[1]),       32'd21);
        chk("b2b_w1_ldata",   wr_data[1],            32'h80600000);

        // Gapped load; start_load with a byte present in RUN must not consume it
        clear_log();
        byte_in    = 8'h02;
        byte_valid = 1'b1;
        pulse_start();
        chk("restart_cpu_hold",  32'(cpu_hold),   32'd1);
        chk("restart_load_done", 32'(load_done),  32'd0);
        chk("restart_ready",     32'(byte_ready), 32'd1);
        load_two_words(1'b1);
        tick();
        chk("gap_load_done", 32'(load_done),       32'd1);
        chk("gap_nwrites",   32'(wr_addr.size()),  32'd2);
        chk("gap_w0_addr",   32'(wr_addr[0]),      32'd20);
        chk("gap_w0_data",   wr_data[0],           32'h80400000);
        chk("gap_w1_addr",   32'(wr_addr[1]),      32'd21);
        chk("gap_w1_data",   wr_data[1],           32'h80600000);
        chk("ready_in_write", 32'(ready_in_write), 32'd0);

        // Oversized header -> ERROR, then recover with an empty program
        clear_log();
        pulse_start();
        send(8'h20, 1'b0);
        tick();
        tick();
        chk("err_flag",     32'(load_error),      32'd1);
        chk("err_cpu_hold", 32'(cpu_hold),        32'd1);
        chk("err_ready",    32'(byte_ready),      32'd0);
        chk("err_done",     32'(load_done),       32'd0);
        chk("err_addr",     32'(ram_address),     32'd20);
        pulse_start();
        chk("err_clear",    32'(load_error),      32'd0);
        send(8'h00, 1'b0);
        chk("empty_done",   32'(load_done),       32'd1);
        chk("empty_error",  32'(load_error),      32'd0);
        chk("err_nwrites",  32'(wr_addr.size()),  32'd0);

        // Reset in the middle of word 1 of a three-word load
        clear_log();
        pulse_start();
        send(8'h03, 1'b0);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        send(8'hAA, 1'b0); send(8'hBB, 1'b0);
        chk("partial_shift", i_ram_input, 32'h3344AABB);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_hold",  32'(cpu_hold),         32'd1);
        chk("mid_rst_ready", 32'(byte_ready),       32'd0);
        chk("mid_rst_done",  32'(load_done),        32'd0);
        chk("mid_rst_data",  i_ram_input,           32'd0);
        tick();
        tick();
        chk("mid_rst_write", 32'(flag_write_i_ram), 32'd0);
        chk("mid_nwrites",   32'(wr_addr.size()),   32'd1);
        chk("mid_w0_addr",   32'(wr_addr[0]),       32'd20);
        chk("mid_w0_data",   wr_data[0],            32'h11223344);

        // Reach RUN, then reload one word from RUN
        pulse_start();
        send(8'h00, 1'b0);
        chk("pre_run_done", 32'(load_done), 32'd1);
        clear_log();
        pulse_start();
        chk("rl_cpu_hold",  32'(cpu_hold),  32'd1);
        chk("rl_load_done", 32'(load_done), 32'd0);
        send(8'h01, 1'b0);
        send(8'hDE, 1'b0); send(8'hAD, 1'b0); send(8'hBE, 1'b0); send(8'hEF, 1'b0);
        pc_address = 10'd5;
        tick();
        chk("rl_done",     32'(load_done),      32'd1);
        chk("rl_hold",     32'(cpu_hold),       32'd0);
        chk("rl_pc_addr",  32'(ram_address),    32'd5);
        chk("rl_nwrites",  32'(wr_addr.size()), 32'd1);
        chk("rl_w0_addr",  32'(wr_addr[0]),     32'd20);
        chk("rl_w0_data",  wr_data[0],          32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
